// File: rtl/ram_data_sta_accum.sv
// ram_data_sta_accum: read-modify-write counter engine with zero-fill and host snapshot reads.
// Define RAM_DATA_STA_SAT_EN for saturating counters plus a sat_flag output.
module ram_data_sta_accum #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int INC_WIDTH  = 8,
    parameter int CLR_ON_RD  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef RAM_DATA_STA_SAT_EN
    output logic                  sat_flag,
`endif
    input  logic                  clr_all,
    output logic                  busy,
    input  logic                  evt_valid,
    output logic                  evt_ready,
    input  logic [ADDR_WIDTH-1:0] evt_idx,
    input  logic [INC_WIDTH-1:0]  evt_inc,
    input  logic                  host_rd_req,
    input  logic [ADDR_WIDTH-1:0] host_rd_addr,
    output logic                  host_rd_ack,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);
    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic [1:0]              pend_q, pend_d;
    logic                    ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    run, force_host, host_sel, evt_go;
    logic [DATA_WIDTH-1:0]   sum;
`ifdef RAM_DATA_STA_SAT_EN
    logic [DATA_WIDTH:0]     sum_w;
    logic                    sat_q;
`endif

    always_comb begin
        run        = !rst && state_q == RUN;
        // a request waiting two cycles steals the next slot from the event stream
        force_host = host_rd_req && pend_q == 2'd2;
        evt_ready  = run && !force_host;
        evt_go     = evt_valid && evt_ready;
        host_sel   = run && host_rd_req && (force_host || !evt_valid);
        busy       = !run;
        ram_rd_addr = host_sel ? host_rd_addr : evt_idx;
`ifdef RAM_DATA_STA_SAT_EN
        sum_w = {1'b0, ram_rd_data} + (DATA_WIDTH+1)'(evt_inc);
        sum   = sum_w[DATA_WIDTH] ? '1 : sum_w[DATA_WIDTH-1:0];
`else
        sum = ram_rd_data + DATA_WIDTH'(evt_inc);
`endif
        ram_wr_en   = !rst && (state_q == CLEAR || evt_go || (host_sel && CLR_ON_RD != 0));
        ram_wr_addr = !run ? clr_ptr_q : evt_go ? evt_idx : host_rd_addr;
        ram_wr_data = evt_go ? sum : '0;
        state_d   = clr_all ? CLEAR : (state_q == CLEAR && &clr_ptr_q) ? RUN : state_q;
        clr_ptr_d = (clr_all || state_q == RUN) ? '0 : clr_ptr_q + 1'b1;
        pend_d    = (host_sel || !host_rd_req) ? 2'd0 : (pend_q == 2'd2 ? 2'd2 : pend_q + 2'd1);
        ack_d     = host_sel;
        data_d    = host_sel ? ram_rd_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            pend_q    <= '0;
            ack_q     <= 1'b0;
            data_q    <= '0;
`ifdef RAM_DATA_STA_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
`ifdef RAM_DATA_STA_SAT_EN
            sat_q     <= evt_go && sum_w[DATA_WIDTH];
`endif
        end
    end

    assign host_rd_ack  = ack_q;
    assign host_rd_data = data_q;
`ifdef RAM_DATA_STA_SAT_EN
    assign sat_flag = sat_q;
`endif
endmodule
